// File: rtl/bp_dma_pkt_responder_pkg.sv
// Purpose: shared types for the DMA packet responder (FSM state encoding).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bp_dma_pkt_responder_pkg;

    // One packet in flight at a time.
    // Reads alternate between issuing the SRAM access and holding the returned beat.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_HOLD  = 2'd2,
        WR       = 2'd3
    } dma_state_e;

endpackage

// File: rtl/bp_dma_pkt_responder.sv
// Purpose: serves cache DMA packets as full-block bursts against an external 1rw sync SRAM.
// Latency: packet accept -> first read beat valid in 2 cycles; read 1 beat/2 cycles, write 1 beat/cycle.
// Backpressure: read beat held stable in RD_HOLD until ready_and; packets/write beats only yumi'd when the FSM can take them.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   dma_pkt_i/_v_i/_yumi_o    {write_not_read, addr} request, consumed only in IDLE
//   dma_data_o/_v_o/_ready_and_i  read beats to the chip (valid/ready)
//   dma_data_i/_v_i/_yumi_o   write beats from the chip (valid/yumi)
//   mem_*                     single-port synchronous SRAM, beat addressed
module bp_dma_pkt_responder
    import bp_dma_pkt_responder_pkg::*;
#(
    parameter int daddr_width_p = 32,
    parameter int fill_width_p  = 64,
    parameter int burst_len_p   = 8,
    parameter int mem_els_p     = 4096
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic [daddr_width_p:0]       dma_pkt_i,
    input  logic                         dma_pkt_v_i,
    output logic                         dma_pkt_yumi_o,

    output logic [fill_width_p-1:0]      dma_data_o,
    output logic                         dma_data_v_o,
    input  logic                         dma_data_ready_and_i,

    input  logic [fill_width_p-1:0]      dma_data_i,
    input  logic                         dma_data_v_i,
    output logic                         dma_data_yumi_o,

    output logic                         mem_v_o,
    output logic                         mem_w_o,
    output logic [$clog2(mem_els_p)-1:0] mem_addr_o,
    output logic [fill_width_p-1:0]      mem_data_o,
    input  logic [fill_width_p-1:0]      mem_data_i
);

    localparam int byte_lg    = $clog2(fill_width_p / 8);
    localparam int blk_lg     = $clog2(burst_len_p);
    localparam int mem_addr_w = $clog2(mem_els_p);
    localparam int base_w     = mem_addr_w - blk_lg;
    localparam int base_lsb   = byte_lg + blk_lg;

    dma_state_e              state_q, state_d;
    logic [blk_lg-1:0]       beat_cnt_q, beat_cnt_d;
    logic [base_w-1:0]       base_q, base_d;
    logic [fill_width_p-1:0] data_q;
    logic                    fresh_q;

    logic              pkt_wnr;
    logic [base_w-1:0] pkt_base;
    logic              last_beat;

    assign pkt_wnr   = dma_pkt_i[daddr_width_p];
    // Bits above the block field are dropped so addresses wrap modulo SRAM size;
    // bits below it are ignored because every burst is block-aligned.
    assign pkt_base  = dma_pkt_i[base_lsb +: base_w];
    assign last_beat = (beat_cnt_q == blk_lg'(burst_len_p - 1));

    logic unused_pkt_bits;
    assign unused_pkt_bits = ^{dma_pkt_i[base_lsb-1:0], dma_pkt_i[daddr_width_p-1:base_lsb+base_w]};

    assign mem_addr_o = {base_q, beat_cnt_q};

    // The SRAM word is valid on mem_data_i during the first RD_HOLD cycle; it is
    // passed straight through then and served from data_q afterwards, so the beat
    // stays stable however long the chip stalls.
    assign dma_data_o = fresh_q ? mem_data_i : data_q;

    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        base_d          = base_q;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_v_o    = 1'b0;
        dma_data_yumi_o = 1'b0;
        mem_v_o         = 1'b0;
        mem_w_o         = 1'b0;
        mem_data_o      = '0;

        case (state_q)
            IDLE: begin
                dma_pkt_yumi_o = dma_pkt_v_i;
                if (dma_pkt_v_i) begin
                    base_d     = pkt_base;
                    beat_cnt_d = '0;
                    state_d    = pkt_wnr ? WR : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                mem_v_o = 1'b1;
                state_d = RD_HOLD;
            end
            RD_HOLD: begin
                dma_data_v_o = 1'b1;
                if (dma_data_ready_and_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + blk_lg'(1);
                        state_d    = RD_ISSUE;
                    end
                end
            end
            WR: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i) begin
                    mem_v_o    = 1'b1;
                    mem_w_o    = 1'b1;
                    mem_data_o = dma_data_i;
                    // Counter wraps to 0 on the last beat, ready for the next packet.
                    beat_cnt_d = beat_cnt_q + blk_lg'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            base_q     <= '0;
            data_q     <= '0;
            fresh_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            base_q     <= base_d;
            fresh_q    <= (state_q == RD_ISSUE);
            if (fresh_q) begin
                data_q <= mem_data_i;
            end
        end
    end

endmodule

// File: tb/tb_bp_dma_pkt_responder.sv
module tb_bp_dma_pkt_responder;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [32:0] dma_pkt_i;
    logic        dma_pkt_v_i;
    logic        dma_pkt_yumi_o;
    logic [63:0] dma_data_o;
    logic        dma_data_v_o;
    logic        dma_data_ready_and_i;
    logic [63:0] dma_data_i;
    logic        dma_data_v_i;
    logic        dma_data_yumi_o;
    logic        mem_v_o;
    logic        mem_w_o;
    logic [11:0] mem_addr_o;
    logic [63:0] mem_data_o;
    logic [63:0] mem_data_i;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    bp_dma_pkt_responder dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .dma_pkt_i            (dma_pkt_i),
        .dma_pkt_v_i          (dma_pkt_v_i),
        .dma_pkt_yumi_o       (dma_pkt_yumi_o),
        .dma_data_o           (dma_data_o),
        .dma_data_v_o         (dma_data_v_o),
        .dma_data_ready_and_i (dma_data_ready_and_i),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_yumi_o      (dma_data_yumi_o),
        .mem_v_o              (mem_v_o),
        .mem_w_o              (mem_w_o),
        .mem_addr_o           (mem_addr_o),
        .mem_data_o           (mem_data_o),
        .mem_data_i           (mem_data_i)
    );

    // Single-port synchronous SRAM model: read data appears the cycle after the read.
    logic [63:0] sram [0:4095];
    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
            else         mem_data_i <= sram[mem_addr_o];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Entry: just after the negedge of the first RD_ISSUE cycle. Exit: negedge after last handshake.
    task automatic read_beats(input int base, input logic [63:0] seed,
                              input int stall_beat, input int stall_len, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            dma_data_ready_and_i = 1'b1;
            #1;
            chk("rd_issue_mem_v", 64'(mem_v_o), 64'd1);
            chk("rd_issue_mem_w", 64'(mem_w_o), 64'd0);
            chk("rd_issue_addr", 64'(mem_addr_o), 64'(base * 8 + b));
            chk("rd_issue_data_v", 64'(dma_data_v_o), 64'd0);
            chk("rd_pkt_yumi_busy", 64'(dma_pkt_yumi_o), 64'd0);
            @(negedge clk_i);
            if (b == stall_beat) begin
                dma_data_ready_and_i = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    chk("stall_data_v", 64'(dma_data_v_o), 64'd1);
                    chk("stall_data", dma_data_o, seed + 64'(b));
                    chk("stall_mem_v", 64'(mem_v_o), 64'd0);
                    @(negedge clk_i);
                end
                dma_data_ready_and_i = 1'b1;
            end
            #1;
            chk("rd_beat_v", 64'(dma_data_v_o), 64'd1);
            chk("rd_beat_data", dma_data_o, seed + 64'(b));
            chk("rd_hold_mem_v", 64'(mem_v_o), 64'd0);
            @(negedge clk_i);
        end
    endtask

    // Entry: just after the negedge of the first WR cycle. Exit: negedge after last yumi.
    task automatic write_beats(input int base, input logic [63:0] seed, input logic gap);
        int b = 0;
        int cyc = 0;
        logic v;
        while (b < 8 && cyc < 64) begin
            v = gap ? ((cyc % 2) == 0) : 1'b1;
            dma_data_v_i = v;
            dma_data_i   = seed + 64'(b);
            #1;
            chk("wr_yumi", 64'(dma_data_yumi_o), 64'(v));
            chk("wr_mem_v", 64'(mem_v_o), 64'(v));
            chk("wr_pkt_yumi_busy", 64'(dma_pkt_yumi_o), 64'd0);
            if (v) begin
                chk("wr_mem_w", 64'(mem_w_o), 64'd1);
                chk("wr_addr", 64'(mem_addr_o), 64'(base * 8 + b));
                chk("wr_mem_data", mem_data_o, seed + 64'(b));
                b++;
            end
            @(negedge clk_i);
            cyc++;
        end
        dma_data_v_i = 1'b0;
        chk("wr_beat_count", 64'(b), 64'd8);
    endtask

    task automatic accept_pkt(input logic wnr, input logic [31:0] addr);
        dma_pkt_i   = {wnr, addr};
        dma_pkt_v_i = 1'b1;
        #1;
        chk("pkt_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        @(negedge clk_i);
        dma_pkt_v_i = 1'b0;
    endtask

    task automatic idle_check();
        // A stray write beat in IDLE must stay pending.
        dma_data_v_i = 1'b1;
        #1;
        chk("idle_data_yumi", 64'(dma_data_yumi_o), 64'd0);
        chk("idle_mem_v", 64'(mem_v_o), 64'd0);
        dma_data_v_i = 1'b0;
        @(negedge clk_i);
    endtask

    typedef struct {
        logic        wnr;
        logic [31:0] addr;
        logic [63:0] seed;
        logic        gap;
        int          stall_beat;
        int          stall_len;
        int          exp_base;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // wnr, addr, seed, gap, stall_beat, stall_len, exp_base
        vecs[0] = '{1'b1, 32'h0000_0040, 64'h1,   1'b0, -1, 0, 1};
        vecs[1] = '{1'b0, 32'h0000_0040, 64'h1,   1'b0,  3, 5, 1};
        vecs[2] = '{1'b1, 32'h0000_8040, 64'h100, 1'b0, -1, 0, 1};
        vecs[3] = '{1'b0, 32'h0000_0040, 64'h100, 1'b0, -1, 0, 1};
        vecs[4] = '{1'b0, 32'h0000_0047, 64'h100, 1'b0, -1, 0, 1};
        vecs[5] = '{1'b1, 32'h0000_01C0, 64'h200, 1'b1, -1, 0, 7};
        vecs[6] = '{1'b0, 32'h0000_01C0, 64'h200, 1'b0,  0, 2, 7};

        reset_n_i            = 1'b0;
        dma_pkt_i            = '0;
        dma_pkt_v_i          = 1'b0;
        dma_data_ready_and_i = 1'b0;
        dma_data_i           = '0;
        dma_data_v_i         = 1'b1;
        #2;
        chk("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
        chk("rst_data_v", 64'(dma_data_v_o), 64'd0);
        chk("rst_data", dma_data_o, 64'd0);
        chk("rst_data_yumi", 64'(dma_data_yumi_o), 64'd0);
        chk("rst_mem_v", 64'(mem_v_o), 64'd0);
        chk("rst_mem_w", 64'(mem_w_o), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        chk("rst_mem_data", mem_data_o, 64'd0);
        dma_data_v_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 7; i++) begin
            accept_pkt(vecs[i].wnr, vecs[i].addr);
            if (vecs[i].wnr) write_beats(vecs[i].exp_base, vecs[i].seed, vecs[i].gap);
            else read_beats(vecs[i].exp_base, vecs[i].seed, vecs[i].stall_beat, vecs[i].stall_len, 8);
            idle_check();
        end

        // Read queued behind a write with pkt_v held high throughout.
        dma_pkt_i   = {1'b1, 32'h0000_0280};
        dma_pkt_v_i = 1'b1;
        #1;
        chk("b2b_wr_yumi", 64'(dma_pkt_yumi_o), 64'd1);
        @(negedge clk_i);
        dma_pkt_i = {1'b0, 32'h0000_0280};
        write_beats(10, 64'h300, 1'b0);
        #1;
        chk("b2b_rd_yumi_next_cycle", 64'(dma_pkt_yumi_o), 64'd1);
        @(negedge clk_i);
        dma_pkt_v_i = 1'b0;
        read_beats(10, 64'h300, -1, 0, 8);
        idle_check();

        // Reset in the middle of a read burst, while beat 4 is being held.
        accept_pkt(1'b0, 32'h0000_01C0);
        read_beats(7, 64'h200, -1, 0, 4);
        dma_data_ready_and_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("mid_beat4_v", 64'(dma_data_v_o), 64'd1);
        chk("mid_beat4_data", dma_data_o, 64'h204);
        dma_data_v_i = 1'b1;
        reset_n_i = 1'b0;
        #1;
        chk("arst_data_v", 64'(dma_data_v_o), 64'd0);
        chk("arst_data", dma_data_o, 64'd0);
        chk("arst_mem_v", 64'(mem_v_o), 64'd0);
        chk("arst_mem_addr", 64'(mem_addr_o), 64'd0);
        chk("arst_data_yumi", 64'(dma_data_yumi_o), 64'd0);
        chk("arst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
        dma_data_v_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        accept_pkt(1'b0, 32'h0000_01C0);
        read_beats(7, 64'h200, -1, 0, 8);
        idle_check();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
